hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Parametrised pipeline stall controller for the MIPS core; next generation of the fixed-function stall block.
- Decodes the fetched opcode and stalls the front end for a configurable number of cycles per hazard class (load, jump), or holds indefinitely on halt until an explicit resume.
- Outputs a combinational stall for the PC and IF stage, plus a one-cycle-delayed stall_pm for program-memory/IF-ID gating.

Parameters:
- OP_W, 6: opcode width; op is compared as an unsigned number, MSB = op[OP_W-1].
- HLT_OPCODE, 6'h11: exact-match halt opcode.
- LD_OPCODE, 6'h14: exact-match load opcode.
- JMP_MATCH, 6'h1C: jump match value, compared as (op & JMP_MASK) == JMP_MATCH.
- JMP_MASK, 6'h3C: jump compare mask; bits that are 0 in the mask are don't-care.
- LD_CYCLES, 1: stall cycles per load; 0 disables the class.
- JMP_CYCLES, 2: stall cycles per jump; 0 disables the class.
- CNT_W, 4: counter width; LD_CYCLES and JMP_CYCLES must each be < 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  OP_W  opcode of the instruction in fetch.
- op_valid  in  1  op is a real instruction; when 0, no detection.
- resume  in  1  single-cycle pulse that releases HALT.
- stall  out  1  combinational front-end stall.
- stall_pm  out  1  stall registered one cycle.
- stall_cause  out  2  00 none, 01 load, 10 jump, 11 halt; valid only while stall=1, otherwise 00.
- halted  out  1  1 while the FSM is in HALT.

Behaviour:
- States: IDLE, CNT, REL, HALT. The remaining-cycle counter is cnt[CNT_W-1:0].
- Reset (sync): state=IDLE, cnt=0, stall_pm=0, cause register=00. During a reset cycle, stall=0, stall_cause=00 and halted=0 regardless of op.
- Detection is active only in IDLE with op_valid=1.
  - Priority is HLT > JMP > LD. A class whose *_CYCLES=0 never matches.
- IDLE, halt match:
  - stall=1 and cause=11 in the same cycle.
  - Next state HALT.
- IDLE, jump or load match with N = JMP_CYCLES or LD_CYCLES:
  - stall=1 and the cause is set in the detection cycle.
  - If N=1, next state is REL.
  - If N>=2, next state is CNT with cnt=N-1 and the cause is latched.
- CNT:
  - stall=1; stall_cause = latched cause; cnt decrements each cycle.
  - When cnt==1, next state is REL.
  - Total stall = N consecutive cycles, including the detection cycle.
- REL (release):
  - One cycle with stall=0. Detection is suppressed, because the stalled op is still on the bus and must not retrigger.
  - Next state is IDLE unconditionally.
- HALT:
  - stall=1, cause=11, halted=1.
  - op and op_valid are ignored.
  - resume=1 moves the FSM to REL next cycle; stall stays 1 in the cycle resume is sampled.
- resume outside HALT has no effect.
- stall_pm is the registered stall: it equals the previous cycle's stall, or 0 after reset.
- Back-to-back hazards: a new hazard can be detected no earlier than the cycle after REL. Minimum gap is one unstalled cycle.
- Reset mid-CNT or mid-HALT aborts immediately. The next cycle is IDLE with detection live.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - Adds output perf_stall_cnt [31:0], counting cycles with stall=1.
  - Saturates at 32'hFFFFFFFF; cleared by reset.
  - Adds output perf_halt_cnt [15:0], counting HALT entries, also saturating.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Load: reset, then op=6'h14, op_valid=1, held 4 cycles.
  - Expect stall=1 for cycle 0 only, stall_cause=01.
  - Cycle 1 stall=0 (REL); stall_pm=1 at cycle 1.
  - Cycle 2 retriggers stall=1.
- Jump: op=6'h1D (mask match), held.
  - Expect stall=1 cycles 0–1, cause=10; cycle 2 stall=0.
  - stall_pm=1 cycles 1–2.
- Priority and halt: op=6'h11 with op_valid=1.
  - Expect stall=1, cause=11, halted=1 from the next cycle, held for 20 cycles.
  - resume pulse at cycle 10: stall=1 that cycle, stall=0 at cycle 11 (REL), halted=0 at cycle 11.
- Parametrised/disable: JMP_CYCLES=5, LD_CYCLES=0.
  - Jump stalls exactly 5 cycles.
  - op=6'h14 never stalls, stall_cause stays 00.
- Reset mid-operation: JMP_CYCLES=5, assert reset at the third stall cycle.
  - Expect stall=0 that cycle and stall_pm=0 next cycle.
  - The jump op still present after reset stalls again immediately.
- op_valid=0 with op=6'h11 for 5 cycles: stall=0, halted=0 throughout.
  - With STALL_PERF_CNT_EN, perf_stall_cnt increments once per stalled cycle in the scenarios above (e.g. 5 after one 5-cycle jump).

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Front-end stall controller: per-class stall lengths for load/jump, hold on halt until resume.
// Optional STALL_PERF_CNT_EN adds saturating stall-cycle and halt-entry counters.
module hazard_stall_ctrl #(
    parameter int                OP_W       = 6,
    parameter logic [OP_W-1:0]   HLT_OPCODE = 6'h11,
    parameter logic [OP_W-1:0]   LD_OPCODE  = 6'h14,
    parameter logic [OP_W-1:0]   JMP_MATCH  = 6'h1C,
    parameter logic [OP_W-1:0]   JMP_MASK   = 6'h3C,
    parameter int                LD_CYCLES  = 1,
    parameter int                JMP_CYCLES = 2,
    parameter int                CNT_W      = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            op_valid,
    input  logic            resume,
    output logic            stall,
    output logic            stall_pm,
    output logic [1:0]      stall_cause,
    output logic            halted
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [15:0]     perf_halt_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, CNT, REL, HALT} state_t;

    localparam logic [1:0]       C_NONE = 2'b00;
    localparam logic [1:0]       C_LD   = 2'b01;
    localparam logic [1:0]       C_JMP  = 2'b10;
    localparam logic [1:0]       C_HLT  = 2'b11;
    localparam logic [CNT_W-1:0] LD_N   = CNT_W'(LD_CYCLES);
    localparam logic [CNT_W-1:0] JMP_N  = CNT_W'(JMP_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       cause_q, cause_n;
    logic             hit_hlt, hit_jmp, hit_ld;
    logic [CNT_W-1:0] hit_len;
    logic [1:0]       hit_cause;

    // A class configured with zero cycles can never match.
    assign hit_hlt = op_valid && (op == HLT_OPCODE);
    assign hit_jmp = op_valid && ((op & JMP_MASK) == JMP_MATCH) && (JMP_CYCLES != 0);
    assign hit_ld  = op_valid && (op == LD_OPCODE) && (LD_CYCLES != 0);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cause_n     = cause_q;
        stall       = 1'b0;
        stall_cause = C_NONE;
        halted      = 1'b0;
        hit_len     = hit_jmp ? JMP_N : LD_N;
        hit_cause   = hit_jmp ? C_JMP : C_LD;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (hit_hlt) begin
                        stall       = 1'b1;
                        stall_cause = C_HLT;
                        state_n     = HALT;
                    end else if (hit_jmp || hit_ld) begin
                        stall       = 1'b1;
                        stall_cause = hit_cause;
                        if (hit_len == ONE) begin
                            state_n = REL;
                        end else begin
                            state_n = CNT;
                            cnt_n   = hit_len - ONE;
                            cause_n = hit_cause;
                        end
                    end
                end
                CNT: begin
                    stall       = 1'b1;
                    stall_cause = cause_q;
                    cnt_n       = cnt - ONE;
                    if (cnt == ONE) state_n = REL;
                end
                // Stalled op is still on the bus here; skipping detection avoids a retrigger.
                REL: state_n = IDLE;
                HALT: begin
                    stall       = 1'b1;
                    stall_cause = C_HLT;
                    halted      = 1'b1;
                    if (resume) state_n = REL;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cause_q  <= C_NONE;
            stall_pm <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cause_q  <= cause_n;
            stall_pm <= stall;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic halt_entry;
    assign halt_entry = (state == IDLE) && (state_n == HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_halt_cnt  <= '0;
        end else begin
            if (stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (halt_entry && (perf_halt_cnt != '1)) perf_halt_cnt <= perf_halt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed table-driven bench for hazard_stall_ctrl: default instance plus a JMP=5/LD=0 instance.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       op_valid;
    logic       resume;

    logic       s0, pm0, h0, s1, pm1, h1;
    logic [1:0] c0, c1;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] psc0, psc1;
    logic [15:0] phc0, phc1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl u0 (
        .clk(clk), .reset(reset), .op(op), .op_valid(op_valid), .resume(resume),
        .stall(s0), .stall_pm(pm0), .stall_cause(c0), .halted(h0)
`ifdef STALL_PERF_CNT_EN
        , .perf_stall_cnt(psc0), .perf_halt_cnt(phc0)
`endif
    );

    hazard_stall_ctrl #(.JMP_CYCLES(5), .LD_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .op(op), .op_valid(op_valid), .resume(resume),
        .stall(s1), .stall_pm(pm1), .stall_cause(c1), .halted(h1)
`ifdef STALL_PERF_CNT_EN
        , .perf_stall_cnt(psc1), .perf_halt_cnt(phc1)
`endif
    );

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       vld;
        logic       res;
        logic       sel;
        logic       s;
        logic       pm;
        logic [1:0] c;
        logic       h;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [5:0] o, input logic vld, input logic res,
                       input logic sel, input logic s, input logic pm, input logic [1:0] c,
                       input logic h);
        vec_t v;
        v.rst = rst; v.op = o; v.vld = vld; v.res = res; v.sel = sel;
        v.s = s; v.pm = pm; v.c = c; v.h = h;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [5:0] o, input logic vld, input logic res);
        @(negedge clk);
        reset = rst; op = o; op_valid = vld; resume = res;
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1; op = '0; op_valid = 1'b0; resume = 1'b0;
        repeat (2) @(posedge clk);

        // default instance: load, jump, halt/resume, op_valid gating, reset mid-halt
        add(1, 6'h11, 1, 0, 0, 0, 0, 2'd0, 0);
        add(0, 6'h14, 1, 0, 0, 1, 0, 2'd1, 0);
        add(0, 6'h14, 1, 0, 0, 0, 1, 2'd0, 0);
        add(0, 6'h14, 1, 0, 0, 1, 0, 2'd1, 0);
        add(0, 6'h14, 1, 0, 0, 0, 1, 2'd0, 0);
        add(0, 6'h14, 0, 0, 0, 0, 0, 2'd0, 0);
        add(0, 6'h1D, 1, 0, 0, 1, 0, 2'd2, 0);
        add(0, 6'h1D, 1, 0, 0, 1, 1, 2'd2, 0);
        add(0, 6'h1D, 1, 0, 0, 0, 1, 2'd0, 0);
        add(0, 6'h1D, 0, 0, 0, 0, 0, 2'd0, 0);
        add(0, 6'h11, 1, 0, 0, 1, 0, 2'd3, 0);
        for (int i = 0; i < 9; i++) add(0, 6'h11, 1, 0, 0, 1, 1, 2'd3, 1);
        add(0, 6'h11, 1, 1, 0, 1, 1, 2'd3, 1);
        add(0, 6'h11, 1, 0, 0, 0, 1, 2'd0, 0);
        add(0, 6'h11, 1, 0, 0, 1, 0, 2'd3, 0);
        add(0, 6'h11, 0, 0, 0, 1, 1, 2'd3, 1);
        add(0, 6'h11, 0, 1, 0, 1, 1, 2'd3, 1);
        add(0, 6'h11, 0, 0, 0, 0, 1, 2'd0, 0);
        for (int i = 0; i < 5; i++) add(0, 6'h11, 0, 0, 0, 0, 0, 2'd0, 0);
        add(0, 6'h00, 0, 1, 0, 0, 0, 2'd0, 0);
        add(0, 6'h00, 0, 0, 0, 0, 0, 2'd0, 0);
        add(0, 6'h11, 1, 0, 0, 1, 0, 2'd3, 0);
        add(0, 6'h11, 0, 0, 0, 1, 1, 2'd3, 1);
        add(1, 6'h11, 0, 0, 0, 0, 1, 2'd0, 0);
        add(0, 6'h14, 1, 0, 0, 1, 0, 2'd1, 0);
        add(0, 6'h14, 1, 0, 0, 0, 1, 2'd0, 0);
        add(0, 6'h14, 0, 0, 0, 0, 0, 2'd0, 0);
        // JMP=5 / LD=0 instance: five-cycle jump, load disabled
        add(1, 6'h00, 0, 0, 1, 0, 0, 2'd0, 0);
        add(0, 6'h1C, 1, 0, 1, 1, 0, 2'd2, 0);
        for (int i = 0; i < 4; i++) add(0, 6'h1C, 1, 0, 1, 1, 1, 2'd2, 0);
        add(0, 6'h1C, 1, 0, 1, 0, 1, 2'd0, 0);
        add(0, 6'h1C, 0, 0, 1, 0, 0, 2'd0, 0);
        for (int i = 0; i < 3; i++) add(0, 6'h14, 1, 0, 1, 0, 0, 2'd0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].op, tbl[i].vld, tbl[i].res);
            check("stall",    i, 32'(tbl[i].sel ? s1  : s0),  32'(tbl[i].s));
            check("stall_pm", i, 32'(tbl[i].sel ? pm1 : pm0), 32'(tbl[i].pm));
            check("cause",    i, 32'(tbl[i].sel ? c1  : c0),  32'(tbl[i].c));
            check("halted",   i, 32'(tbl[i].sel ? h1  : h0),  32'(tbl[i].h));
        end

        // reset on the third cycle of a 5-cycle jump, then the same op retriggers
        step(0, 6'h1C, 1, 0); check("rm_stall", 0, 32'(s1), 32'd1);
        step(0, 6'h1C, 1, 0); check("rm_stall", 1, 32'(s1), 32'd1);
        step(1, 6'h1C, 1, 0); check("rm_stall", 2, 32'(s1), 32'd0);
        check("rm_cause", 2, 32'(c1), 32'd0);
        step(0, 6'h1C, 1, 0); check("rm_stall", 3, 32'(s1), 32'd1);
        check("rm_pm", 3, 32'(pm1), 32'd0);
        check("rm_cause", 3, 32'(c1), 32'd2);
        n = 1;
        for (int i = 0; i < 10; i++) begin
            step(0, 6'h1C, 0, 0);
            if (s1) n++;
            else break;
        end
        check("rm_len", 4, 32'(n), 32'd5);
`ifdef STALL_PERF_CNT_EN
        check("perf_stall", 0, psc1, 32'd5);
        step(0, 6'h11, 1, 0);
        step(0, 6'h11, 0, 0);
        check("perf_halt", 0, 32'(phc1), 32'd1);
        check("perf_stall", 1, psc1, 32'd6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
